// File: rtl/hostctrl_loader_if.sv
// rtl/hostctrl_loader_if.sv - host byte handshake plus Wishbone write port of the loader
interface hostctrl_loader_if #(
    parameter int ADR_WIDTH = 32
);
    logic [7:0]           hostctrl_data;
    logic                 hostctrl_valid;
    logic                 hostctrl_done;
    logic                 hostctrl_ack_data;
    logic                 hostctrl_ack;
    logic [ADR_WIDTH-1:0] wb_adr_o;
    logic [31:0]          wb_dat_o;
    logic [3:0]           wb_sel_o;
    logic                 wb_we_o;
    logic                 wb_cyc_o;
    logic                 wb_stb_o;
    logic [2:0]           wb_cti_o;
    logic [1:0]           wb_bte_o;
    logic [31:0]          wb_dat_i;
    logic                 wb_ack_i;
    logic                 wb_err_i;

    modport master (
        input  hostctrl_data, hostctrl_valid, hostctrl_done,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output hostctrl_ack_data, hostctrl_ack,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );

    modport slave (
        output hostctrl_data, hostctrl_valid, hostctrl_done,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  hostctrl_ack_data, hostctrl_ack,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );
endinterface

// File: rtl/hostctrl_loader.sv
// rtl/hostctrl_loader.sv - assembles 8 host bytes into address/data words and writes them over Wishbone
module hostctrl_loader #(
    parameter int WB_TIMEOUT = 256,
    parameter int ADR_WIDTH  = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    hostctrl_loader_if.master    bus,
    output logic                 cpu_rst_o,
    output logic                 load_err_o,
    output logic [31:0]          word_cnt_o
);
    typedef enum logic [2:0] {
        RX,
        RX_RELEASE,
        WB_WRITE,
        WORD_ACK,
        DONE
    } state_t;

    localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
    localparam int AW_CP = (ADR_WIDTH < 32) ? ADR_WIDTH : 32;

    state_t              state, state_nxt;
    logic [3:0]          byte_idx, byte_idx_nxt;
    logic [7:0][7:0]     word_buf, word_buf_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
    logic [31:0]         word_cnt_nxt;
    logic                load_err_nxt;
    logic                ack_data_q, ack_data_nxt;

    logic [31:0]          wr_adr;
    logic [31:0]          wr_dat;
    logic [ADR_WIDTH-1:0] adr_ext;
    logic                 misaligned;
    logic                 bus_active;
    logic                 unused_dat;

    // Slot 0 lands in the least significant byte, so the packed halves are already little-endian words.
    assign wr_adr     = word_buf[3:0];
    assign wr_dat     = word_buf[7:4];
    assign misaligned = (wr_adr[1:0] != 2'b00);
    assign bus_active = (state == WB_WRITE) && !misaligned;
    assign unused_dat = ^bus.wb_dat_i;

    always_comb begin
        adr_ext              = '0;
        adr_ext[AW_CP-1:0]   = wr_adr[AW_CP-1:0];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= RX;
            byte_idx   <= '0;
            word_buf   <= '0;
            tmo_cnt    <= '0;
            word_cnt_o <= '0;
            load_err_o <= 1'b0;
            ack_data_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_idx   <= byte_idx_nxt;
            word_buf   <= word_buf_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            word_cnt_o <= word_cnt_nxt;
            load_err_o <= load_err_nxt;
            ack_data_q <= ack_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        word_buf_nxt = word_buf;
        tmo_cnt_nxt  = tmo_cnt;
        word_cnt_nxt = word_cnt_o;
        load_err_nxt = load_err_o;
        ack_data_nxt = 1'b0;

        case (state)
            RX: begin
                if (bus.hostctrl_done && (byte_idx == 4'd0)) begin
                    state_nxt = DONE;
                end else if (bus.hostctrl_valid) begin
                    word_buf_nxt[byte_idx[2:0]] = bus.hostctrl_data;
                    byte_idx_nxt                = byte_idx + 4'd1;
                    ack_data_nxt                = 1'b1;
                    state_nxt                   = RX_RELEASE;
                end
            end
            // Waiting for valid to drop is what keeps a held-high byte from being captured twice.
            RX_RELEASE: begin
                if (!bus.hostctrl_valid) begin
                    if (byte_idx == 4'd8) begin
                        byte_idx_nxt = '0;
                        tmo_cnt_nxt  = '0;
                        state_nxt    = WB_WRITE;
                    end else begin
                        state_nxt = RX;
                    end
                end
            end
            WB_WRITE: begin
                if (misaligned || bus.wb_err_i) begin
                    load_err_nxt = 1'b1;
                    state_nxt    = WORD_ACK;
                end else if (bus.wb_ack_i) begin
                    word_cnt_nxt = word_cnt_o + 32'd1;
                    state_nxt    = WORD_ACK;
                end else if (tmo_cnt == TMO_W'(WB_TIMEOUT - 1)) begin
                    load_err_nxt = 1'b1;
                    state_nxt    = WORD_ACK;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            WORD_ACK: begin
                state_nxt = RX;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RX;
            end
        endcase
    end

    // Bus strobes decode straight from the state register so the async reset drops them at once.
    assign bus.wb_cyc_o          = bus_active;
    assign bus.wb_stb_o          = bus_active;
    assign bus.wb_we_o           = bus_active;
    assign bus.wb_sel_o          = bus_active ? 4'hF : 4'h0;
    assign bus.wb_cti_o          = 3'b000;
    assign bus.wb_bte_o          = 2'b00;
    assign bus.wb_adr_o          = bus_active ? adr_ext : '0;
    assign bus.wb_dat_o          = bus_active ? wr_dat : 32'd0;
    assign bus.hostctrl_ack_data = ack_data_q;
    assign bus.hostctrl_ack      = (state == WORD_ACK);
    assign cpu_rst_o             = (state != DONE);
endmodule

// File: tb/tb_hostctrl_loader.sv
// tb/tb_hostctrl_loader.sv - self-checking bench for hostctrl_loader
module tb_hostctrl_loader;
    localparam int TMO = 16;
    localparam int AW  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rst_o;
    logic        load_err_o;
    logic [31:0] word_cnt_o;

    always #5 clk = ~clk;

    hostctrl_loader_if #(.ADR_WIDTH(AW)) lif ();

    hostctrl_loader #(.WB_TIMEOUT(TMO), .ADR_WIDTH(AW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (lif),
        .cpu_rst_o  (cpu_rst_o),
        .load_err_o (load_err_o),
        .word_cnt_o (word_cnt_o)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    int   n_cmp = 0;
    int   n_bad = 0;

    // model state
    wr_t         exp_q[$];
    logic [31:0] m_cnt;
    bit          m_err;
    bit          done_ok;
    int          n_ackd, n_ack, n_wr, cyc_len, last_len;
    logic [31:0] last_adr, last_dat;

    // slave behaviour: 0 ack, 1 err, 2 silent, 3 ack+err together
    int slv_mode  = 0;
    int slv_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : slave
        int cnt;
        cnt = 0;
        lif.wb_ack_i = 1'b0;
        lif.wb_err_i = 1'b0;
        lif.wb_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !lif.wb_cyc_o || lif.wb_ack_i || lif.wb_err_i) begin
                lif.wb_ack_i = 1'b0;
                lif.wb_err_i = 1'b0;
                if (!lif.wb_cyc_o) cnt = 0;
            end else begin
                cnt++;
                if (cnt > slv_delay) begin
                    lif.wb_ack_i = (slv_mode == 0) || (slv_mode == 3);
                    lif.wb_err_i = (slv_mode == 1) || (slv_mode == 3);
                end
            end
        end
    end

    initial begin : compare
        bit prev_cyc, term_pending, prev_ackd, prev_ack, prev_err, had_cyc;
        wr_t head;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_cnt = 0; m_err = 0;
                n_ackd = 0; n_ack = 0; n_wr = 0; cyc_len = 0;
                prev_cyc = 0; term_pending = 0; prev_ackd = 0; prev_ack = 0; prev_err = 0; had_cyc = 0;
            end else begin
                check("word_cnt", word_cnt_o, m_cnt);
                if (!done_ok) check("cpu_rst_held", cpu_rst_o, 1);
                if (prev_err) check("load_err_sticky", load_err_o, 1);
                if (term_pending) check("cyc_after_term", lif.wb_cyc_o, 0);
                else if (prev_cyc) check("cyc_held", lif.wb_cyc_o, 1);
                term_pending = 0;
                if (lif.wb_cyc_o) begin
                    if (!prev_cyc) begin n_wr++; cyc_len = 0; had_cyc = 1; end
                    cyc_len++;
                    last_adr = lif.wb_adr_o;
                    last_dat = lif.wb_dat_o;
                    check("cyc_len_bound", cyc_len <= TMO, 1);
                    check("queue_nonempty_in_cyc", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        head = exp_q[0];
                        check("adr", lif.wb_adr_o, head.adr);
                        check("dat", lif.wb_dat_o, head.dat);
                        check("adr_aligned_in_cyc", head.adr % 4, 0);
                    end
                    check("stb_we_sel", {lif.wb_stb_o, lif.wb_we_o, lif.wb_sel_o}, 6'b11_1111);
                    check("cti_bte", {lif.wb_cti_o, lif.wb_bte_o}, 0);
                    if (lif.wb_err_i) begin
                        m_err = 1; term_pending = 1; last_len = cyc_len;
                    end else if (lif.wb_ack_i) begin
                        m_cnt = m_cnt + 1; term_pending = 1; last_len = cyc_len;
                    end else if (cyc_len == TMO) begin
                        m_err = 1; term_pending = 1; last_len = cyc_len;
                    end
                end
                prev_cyc = lif.wb_cyc_o;
                if (lif.hostctrl_ack_data) begin
                    check("ack_data_one_cycle", prev_ackd, 0);
                    n_ackd++;
                end
                if (lif.hostctrl_ack) begin
                    check("ack_one_cycle", prev_ack, 0);
                    check("ack_has_word", exp_q.size() != 0, 1);
                    n_ack++;
                    if (exp_q.size() != 0) begin
                        head = exp_q.pop_front();
                        if (head.adr % 4 != 0) m_err = 1;
                        check("word_bus_cycle", had_cyc, head.adr % 4 == 0);
                        check("load_err_at_ack", load_err_o, m_err);
                    end
                    had_cyc = 0;
                end
                prev_ackd = lif.hostctrl_ack_data;
                prev_ack  = lif.hostctrl_ack;
                prev_err  = load_err_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        bit got;
        got = 0;
        lif.hostctrl_data  = b;
        lif.hostctrl_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            if (lif.hostctrl_ack_data) got = 1;
        end
        check("byte_accepted", got, 1);
        for (int i = 1; i < hold && got; i++) tick();
        lif.hostctrl_valid = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [7:0] bs [8]);
        wr_t w;
        w.adr = 32'(bs[0]) + 32'(bs[1]) * 256 + 32'(bs[2]) * 65536 + 32'(bs[3]) * 16777216;
        w.dat = 32'(bs[4]) + 32'(bs[5]) * 256 + 32'(bs[6]) * 65536 + 32'(bs[7]) * 16777216;
        exp_q.push_back(w);
    endtask

    task automatic wait_word_ack();
        bit got;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (lif.hostctrl_ack) got = 1;
        end
        check("word_acked", got, 1);
    endtask

    task automatic send_word(input logic [7:0] bs [8], input int hold, input bit wait_ack);
        push_word(bs);
        for (int i = 0; i < 8; i++) send_byte(bs[i], hold);
        if (wait_ack) begin
            wait_word_ack();
            tick();
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : stim
        logic [7:0] bs [8];
        int         base;
        bit         got;
        lif.hostctrl_data  = 8'h00;
        lif.hostctrl_valid = 1'b0;
        lif.hostctrl_done  = 1'b0;
        done_ok = 0;
        repeat (3) tick();
        check("rst_cpu_rst", cpu_rst_o, 1);
        check("rst_cyc_stb_we", {lif.wb_cyc_o, lif.wb_stb_o, lif.wb_we_o}, 0);
        check("rst_adr_dat", {lif.wb_adr_o, lif.wb_dat_o}, 0);
        check("rst_sel_cti_bte", {lif.wb_sel_o, lif.wb_cti_o, lif.wb_bte_o}, 0);
        check("rst_acks", {lif.hostctrl_ack_data, lif.hostctrl_ack}, 0);
        check("rst_err_cnt", {load_err_o, word_cnt_o}, 0);
        rst_n = 1'b1;
        tick();

        // reference word, clean handshake
        slv_mode = 0; slv_delay = 2;
        bs = '{8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_word(bs, 1, 1);
        check("w1_adr", last_adr, 32'h0000_0100);
        check("w1_dat", last_dat, 32'hDEAD_BEEF);
        check("w1_ack_data_cnt", n_ackd, 8);
        check("w1_ack_cnt", n_ack, 1);
        check("w1_word_cnt", word_cnt_o, 1);
        check("w1_no_err", load_err_o, 0);

        // valid held 5 cycles per byte
        slv_delay = 0;
        bs = '{8'h04, 8'h02, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_word(bs, 5, 1);
        check("hold_ack_data_cnt", n_ackd, 16);
        check("hold_adr", last_adr, 32'h0000_0204);
        check("hold_dat", last_dat, 32'h1234_5678);
        check("hold_word_cnt", word_cnt_o, 2);

        // misaligned address
        bs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_word(bs, 1, 1);
        check("misal_no_cyc", n_wr, 2);
        check("misal_err", load_err_o, 1);
        check("misal_ack", n_ack, 3);
        check("misal_word_cnt", word_cnt_o, 2);

        // slave error, then ack+err together
        slv_mode = 1; slv_delay = 1;
        bs = '{8'h08, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_word(bs, 1, 1);
        check("err_word_cnt", word_cnt_o, 2);
        slv_mode = 3; slv_delay = 0;
        bs = '{8'h0C, 8'h00, 8'h00, 8'h80, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        send_word(bs, 1, 1);
        check("ackerr_word_cnt", word_cnt_o, 2);
        check("ackerr_adr", last_adr, 32'h8000_000C);

        // silent slave -> timeout
        slv_mode = 2;
        bs = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_word(bs, 1, 1);
        check("tmo_cyc_len", last_len, TMO);
        check("tmo_err", load_err_o, 1);
        check("tmo_ack_cnt", n_ack, 6);
        check("tmo_word_cnt", word_cnt_o, 2);

        do_reset();
        check("rst2_err_cleared", load_err_o, 0);
        check("rst2_cnt_cleared", word_cnt_o, 0);

        // reset in the middle of a bus cycle
        bs = '{8'h14, 8'h00, 8'h00, 8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        send_word(bs, 1, 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (lif.wb_cyc_o) got = 1;
            else tick();
        end
        check("abort_cyc_started", got, 1);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async_cyc_stb", {lif.wb_cyc_o, lif.wb_stb_o, lif.wb_we_o}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // partial word discarded by reset
        slv_mode = 0; slv_delay = 1;
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bs = '{8'(8'h30 + 4 * k), 8'h00, 8'h00, 8'h00, 8'(k), 8'h5A, 8'h00, 8'h00};
            send_word(bs, 1, 1);
        end
        check("fresh_adr", last_adr, 32'h0000_0038);
        check("fresh_dat", last_dat, 32'h0000_5A02);
        done_ok = 1;
        lif.hostctrl_done = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (!cpu_rst_o) got = 1;
        end
        check("done_cpu_rst_released", cpu_rst_o, 0);
        check("done_word_cnt", word_cnt_o, 3);

        // DONE ignores further bytes
        base = n_ackd;
        lif.hostctrl_data  = 8'h55;
        lif.hostctrl_valid = 1'b1;
        repeat (10) tick();
        lif.hostctrl_valid = 1'b0;
        tick();
        check("done_no_ack_data", n_ackd, base);
        check("done_no_bus", n_wr, 3);
        check("done_stays", cpu_rst_o, 0);

        // done raised mid-word is ignored until the word completes
        lif.hostctrl_done = 1'b0;
        done_ok = 0;
        do_reset();
        bs = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        push_word(bs);
        for (int i = 0; i < 4; i++) send_byte(bs[i], 1);
        lif.hostctrl_done = 1'b1;
        for (int i = 4; i < 8; i++) send_byte(bs[i], 1);
        wait_word_ack();
        done_ok = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (!cpu_rst_o) got = 1;
        end
        check("middone_released", cpu_rst_o, 0);
        check("middone_word_cnt", word_cnt_o, 1);
        check("middone_adr", last_adr, 32'h0000_0040);
        check("middone_dat", last_dat, 32'h0403_0201);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
